// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV M-extension unit.
//   funct3_e : RV M funct3 encodings (MUL .. REMU)
//   state_e  : control FSM states
//   W_ITERS  : iteration count for W forms
//   CNT_W    : width of the iteration counter (holds up to 64)
`ifndef XLEN
`define XLEN 64
`endif

package muldiv_pkg;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam int W_ITERS = 32;
  localparam int CNT_W   = 7;

endpackage

// File: rtl/muldiv_prep.sv
// Combinational operand conditioning for muldiv_iter.
//   funct3, word : requested operation (word ignored unless XLEN=64)
//   a, b         : raw rs1/rs2 values
//   op, word_eff : effective operation (illegal MULH*W folded to MUL)
//   a_mag, b_mag : operand magnitudes after W truncation/extension
//   sa, sb       : operand sign flags (0 for operands treated as unsigned)
//   special      : divide-by-zero or signed overflow, no iteration needed
//   spec_res     : result for the special case (before W sign-extension)
module muldiv_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output funct3_e         op,
  output logic            word_eff,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            sa,
  output logic            sb,
  output logic            special,
  output logic [XLEN-1:0] spec_res
);

  logic            a_signed;
  logic            b_signed;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] min_val;
  logic            div_zero;
  logic            overflow;

  // NOTE: every output of a combinational block is assigned on every path
  // (here unconditionally, in order) so no latch is inferred.
  always_comb begin
    word_eff = (XLEN == 64) && word;
    op       = funct3_e'(funct3);
    if (word_eff && (op inside {F_MULH, F_MULHSU, F_MULHU})) op = F_MUL;

    // MUL only needs the low product bits, which are sign-agnostic.
    a_signed = op inside {F_MULH, F_MULHSU, F_DIV, F_REM};
    b_signed = op inside {F_MULH, F_DIV, F_REM};

    a_ext = a;
    b_ext = b;
    if (word_eff) begin
      a_ext = a_signed ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0]);
      b_ext = b_signed ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0]);
    end

    sa    = a_signed & a_ext[XLEN-1];
    sb    = b_signed & b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;

    // Most-negative value at the operating width, already sign-extended.
    min_val = word_eff ? XLEN'($signed(32'h8000_0000))
                       : {1'b1, {(XLEN-1){1'b0}}};

    div_zero = funct3[2] && (b_ext == '0);
    overflow = funct3[2] && !funct3[0] && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero || overflow;

    // funct3[1] selects remainder over quotient within the divide group.
    if (div_zero) spec_res = funct3[1] ? a_ext : '1;
    else          spec_res = funct3[1] ? '0 : a_ext;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV M-extension execute unit (radix-2 multiply / restoring divide).
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous abort of any in-flight operation
//   in_valid / in_ready   : request handshake
//   in_funct3, in_word    : operation select (in_word only meaningful at XLEN=64)
//   in_a, in_b, in_rd     : operands and destination tag
//   out_valid / out_ready : result handshake
//   out_data, out_rd      : result and its tag, held stable until accepted
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd
);

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt;
  funct3_e           op;
  logic              word, sa, sb;
  logic [2*XLEN-1:0] acc, acc_n;   // product, or remainder in the low half
  logic [XLEN-1:0]   m, m_n;       // multiplier / dividend shifting out, quotient in
  logic [XLEN-1:0]   b_reg;

  funct3_e           p_op;
  logic              p_word, p_sa, p_sb, p_special;
  logic [XLEN-1:0]   p_a_mag, p_b_mag, p_spec_res, spec_final;

  logic              accept;
  logic [XLEN:0]     shifted, diff;
  logic              qbit;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, raw, result;

  muldiv_prep #(.XLEN(XLEN)) u_prep (
    .funct3   (in_funct3),
    .word     (in_word),
    .a        (in_a),
    .b        (in_b),
    .op       (p_op),
    .word_eff (p_word),
    .a_mag    (p_a_mag),
    .b_mag    (p_b_mag),
    .sa       (p_sa),
    .sb       (p_sb),
    .special  (p_special),
    .spec_res (p_spec_res)
  );

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign spec_final = p_word ? XLEN'($signed(p_spec_res[31:0])) : p_spec_res;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = p_special ? DONE : CALC;
      CALC:    if (cnt == '0) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // One iteration step. Both algorithms consume m from its MSB; W forms
  // pre-align the 32-bit operand to the top of m so the same step applies.
  always_comb begin
    shifted = {acc[XLEN-1:0], m[XLEN-1]};
    diff    = shifted - {1'b0, b_reg};
    qbit    = !diff[XLEN];
    if (op[2]) begin
      acc_n = {{XLEN{1'b0}}, qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0]};
      m_n   = {m[XLEN-2:0], qbit};
    end else begin
      acc_n = {acc[2*XLEN-2:0], 1'b0} + (m[XLEN-1] ? {{XLEN{1'b0}}, b_reg} : '0);
      m_n   = {m[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection once the magnitudes are complete.
  always_comb begin
    prod = (sa ^ sb) ? -acc : acc;
    quo  = (sa ^ sb) ? -m : m;
    rem  = sa ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    if (op[2])            raw = op[1] ? rem : quo;
    else if (op == F_MUL) raw = prod[XLEN-1:0];
    else                  raw = prod[2*XLEN-1:XLEN];
    result = word ? XLEN'($signed(raw[31:0])) : raw;
  end

  // NOTE: the datapath registers are reset too, so no stale operand or result
  // is visible on out_data/out_rd after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op       <= F_MUL;
      word     <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      acc      <= '0;
      m        <= '0;
      b_reg    <= '0;
      out_data <= '0;
      out_rd   <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (accept) begin
          op     <= p_op;
          word   <= p_word;
          sa     <= p_sa;
          sb     <= p_sb;
          out_rd <= in_rd;
          b_reg  <= p_b_mag;
          acc    <= '0;
          m      <= p_word ? (p_a_mag << (XLEN - W_ITERS)) : p_a_mag;
          cnt    <= p_word ? CNT_W'(W_ITERS) : CNT_W'(XLEN);
          if (p_special) out_data <= spec_final;
        end
        CALC: if (cnt != '0) begin
          acc <= acc_n;
          m   <= m_n;
          cnt <= cnt - 1'b1;
        end else begin
          out_data <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: an XLEN=64 and an XLEN=32 instance
// share one stimulus bus; sel32 picks which one a transaction targets.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_word = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel32 = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [63:0] in_a = '0, in_b = '0;
  logic [4:0]  in_rd = '0;

  logic        in_ready64, out_valid64, in_ready32, out_valid32;
  logic [63:0] out_data64;
  logic [31:0] out_data32;
  logic [4:0]  out_rd64, out_rd32;

  logic        ready_s, valid_s;
  logic [63:0] data_s;
  logic [4:0]  rd_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid & ~sel32), .in_ready(in_ready64),
    .in_funct3(in_funct3), .in_word(in_word), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64), .out_rd(out_rd64)
  );

  muldiv_iter #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid & sel32), .in_ready(in_ready32),
    .in_funct3(in_funct3), .in_word(1'b0), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_rd(in_rd),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32), .out_rd(out_rd32)
  );

  assign ready_s = sel32 ? in_ready32 : in_ready64;
  assign valid_s = sel32 ? out_valid32 : out_valid64;
  assign data_s  = sel32 ? {32'b0, out_data32} : out_data64;
  assign rd_s    = sel32 ? out_rd32 : out_rd64;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic at width n using wide signed integers; overflow
  // cases fall out naturally, only divide-by-zero needs a rule.
  function automatic logic [63:0] calc(input logic [2:0] f, input logic [63:0] a,
                                       input logic [63:0] b, input int n);
    logic signed [127:0] as_, bs_, au, bu, r;
    logic signed [31:0]  a32, b32;
    logic signed [63:0]  a64, b64;
    logic [63:0]         mask;
    a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b;
    if (n == 32) begin
      as_ = a32; bs_ = b32; au = {96'b0, a[31:0]}; bu = {96'b0, b[31:0]};
      mask = 64'hFFFF_FFFF;
    end else begin
      as_ = a64; bs_ = b64; au = {64'b0, a}; bu = {64'b0, b};
      mask = '1;
    end
    case (f)
      3'd0:    r = au * bu;
      3'd1:    r = (as_ * bs_) >>> n;
      3'd2:    r = (as_ * bu) >>> n;
      3'd3:    r = (au * bu) >> n;
      3'd4:    r = (bu == 0) ? -128'sd1 : as_ / bs_;
      3'd5:    r = (bu == 0) ? -128'sd1 : au / bu;
      3'd6:    r = (bu == 0) ? as_ : as_ % bs_;
      default: r = (bu == 0) ? au : au % bu;
    endcase
    return 64'(r) & mask;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b, input bit x32);
    logic [2:0]         f;
    logic [63:0]        r;
    logic signed [31:0] s;
    if (x32) return calc(f3, a, b, 32);
    if (!w)  return calc(f3, a, b, 64);
    f = (f3 inside {3'd1, 3'd2, 3'd3}) ? 3'd0 : f3;
    r = calc(f, a, b, 32);
    s = r[31:0];
    return 64'(s);
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b, input bit x32);
    int n;
    n = (x32 || w) ? 32 : 64;
    if (!f3[2]) return n + 1;
    if (n == 32) begin
      if (b[31:0] == 32'h0) return 1;
      if (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
    end else begin
      if (b == 64'h0) return 1;
      if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    end
    return n + 1;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, output bit ok);
    int guard;
    @(negedge clk);
    in_funct3 = f3; in_word = w; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
    guard = 0;
    while (!ready_s && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ok = ready_s;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency = edges after the accept edge until out_valid is seen.
  task automatic wait_result(output logic [63:0] res, output logic [4:0] rdo, output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (valid_s) begin
        lat = k;
        break;
      end
    end
    res = data_s;
    rdo = rd_s;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic watch_quiet(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (valid_s) seen++;
    end
  endtask

  task automatic run_and_check(input string name, input bit x32, input logic [2:0] f3,
                               input logic w, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input logic [63:0] exp, input int lat_exp);
    bit          ok;
    logic [63:0] res;
    logic [4:0]  rdo;
    int          lat;
    sel32 = x32;
    issue(f3, w, a, b, rd, ok);
    check({name, "_accept"}, 64'(ok), 64'd1);
    wait_result(res, rdo, lat);
    check({name, "_data"}, res, exp);
    check({name, "_rd"}, 64'(rdo), 64'(rd));
    check({name, "_latency"}, 64'(lat), 64'(lat_exp));
    if (lat > 0) handshake();
  endtask

  typedef struct {
    string       name;
    bit          x32;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit          ok;
    logic [63:0] d0, res, a, b;
    logic [4:0]  r0, rdo;
    logic [2:0]  f3;
    logic        w;
    int          bad, seen, lat;

    vecs.push_back('{"mul64",       0, 3'd0, 1'b0, 64'h1122_3344_AADD_EEFF, 64'd2, 64'h2244_6689_55BB_DDFE, 65});
    vecs.push_back('{"mulhu_ones",  0, 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{"mulh_m1",     0, 3'd1, 1'b0, '1, '1, 64'h0, 65});
    vecs.push_back('{"mulhsu_m1x2", 0, 3'd2, 1'b0, '1, 64'd2, '1, 65});
    vecs.push_back('{"divw",        0, 3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33});
    vecs.push_back('{"remw",        0, 3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, '1, 33});
    vecs.push_back('{"div_neg",     0, 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    vecs.push_back('{"rem_neg",     0, 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65});
    vecs.push_back('{"divu_zero",   0, 3'd5, 1'b0, 64'd5, 64'd0, '1, 1});
    vecs.push_back('{"remu_zero",   0, 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1});
    vecs.push_back('{"div_ovf",     0, 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{"rem_ovf",     0, 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1});
    vecs.push_back('{"divw_ovf",    0, 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{"mulhw_illeg", 0, 3'd1, 1'b1, 64'd3, 64'd5, 64'd15, 33});
    vecs.push_back('{"remuw_zero",  0, 3'd7, 1'b1, 64'hFFFF_FFFF, 64'd0, '1, 1});
    vecs.push_back('{"divuw_sext",  0, 3'd5, 1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33});
    vecs.push_back('{"mulw_wrap",   0, 3'd0, 1'b1, 64'h1_8000_0000, 64'd2, 64'h0, 33});
    vecs.push_back('{"x32_mulh",    1, 3'd1, 1'b0, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33});
    vecs.push_back('{"x32_div",     1, 3'd4, 1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 33});
    vecs.push_back('{"x32_divu_z",  1, 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF, 1});
    vecs.push_back('{"x32_rem_ovf", 1, 3'd6, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1});

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    check("rst_in_ready64",  64'(in_ready64),  64'd1);
    check("rst_out_data64",  out_data64,       64'd0);
    check("rst_out_rd64",    64'(out_rd64),    64'd0);
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_out_data32",  64'(out_data32),  64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    foreach (vecs[i])
      run_and_check(vecs[i].name, vecs[i].x32, vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b,
                    5'(i + 1), vecs[i].exp, vecs[i].lat);

    // Backpressure: result held for 10 cycles with out_ready low
    sel32 = 1'b0;
    issue(3'd0, 1'b0, 64'd123456789, 64'd987654321, 5'd7, ok);
    wait_result(d0, r0, lat);
    check("bp_data", d0, model(3'd0, 1'b0, 64'd123456789, 64'd987654321, 0));
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (data_s !== d0 || rd_s !== r0 || ready_s !== 1'b0 || valid_s !== 1'b1) bad++;
    end
    check("bp_hold_stable", 64'(bad), 64'd0);
    handshake();
    check("bp_in_ready_after", 64'(ready_s), 64'd1);
    check("bp_out_valid_after", 64'(valid_s), 64'd0);
    run_and_check("b2b_first", 0, 3'd5, 1'b0, 64'd1000, 64'd7, 5'd9, 64'd142, 65);
    run_and_check("b2b_second", 0, 3'd7, 1'b0, 64'd1000, 64'd7, 5'd10, 64'd6, 65);

    // flush during the 20th iteration
    issue(3'd4, 1'b0, 64'd99999, 64'd3, 5'd11, ok);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_in_ready_forced", 64'(ready_s), 64'd0);
    check("flush_out_valid", 64'(valid_s), 64'd0);
    flush = 1'b0;
    #1;
    check("flush_idle", 64'(ready_s), 64'd1);
    watch_quiet(80, seen);
    check("flush_no_result", 64'(seen), 64'd0);

    // flush with a concurrent request: request must be dropped
    @(negedge clk);
    in_funct3 = 3'd5; in_word = 1'b0; in_a = 64'd5; in_b = 64'd0; in_rd = 5'd12;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_req_dropped", 64'(ready_s), 64'd1);
    watch_quiet(5, seen);
    check("flush_req_no_result", 64'(seen), 64'd0);
    run_and_check("after_flush", 0, 3'd0, 1'b0, 64'd6, 64'd7, 5'd13, 64'd42, 65);

    // Reset mid-CALC
    issue(3'd0, 1'b0, 64'd12345, 64'd6789, 5'd14, ok);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_calc_out_valid", 64'(valid_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_calc_in_ready", 64'(ready_s), 64'd1);
    watch_quiet(70, seen);
    check("rst_calc_no_result", 64'(seen), 64'd0);

    // Reset while a result is pending
    issue(3'd5, 1'b0, 64'd5, 64'd0, 5'd21, ok);
    wait_result(res, rdo, lat);
    check("rst_done_pending", 64'(valid_s), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", 64'(valid_s), 64'd0);
    check("rst_done_out_data", data_s, 64'd0);
    check("rst_done_out_rd", 64'(rd_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_done_in_ready", 64'(ready_s), 64'd1);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      bit x32;
      x32 = (i >= 30);
      f3  = 3'($urandom_range(0, 7));
      w   = x32 ? 1'b0 : 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: b = '1;
        2: begin a = (x32 || w) ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
        3: b = 64'($urandom_range(1, 9));
        4: b = {32'h0, $urandom};
        default: ;
      endcase
      run_and_check($sformatf("rand%0d_f%0d_w%0d", i, f3, w), x32, f3, w, a, b, 5'(i),
                    model(f3, w, a, b, x32), exp_lat(f3, w, a, b, x32));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
